vr_source: RTL and testbench
============================

Name: vr_source

Overview:
- Transmit end of the valid_ready interface: drives valid/data toward any valid_ready.Slave.
- Issues a burst of num_beats transfers after a start pulse, with a programmable idle gap of delay cycles before each beat.
- Generates a deterministic data pattern, so a downstream consumer can be checked beat by beat.
- Used as a traffic generator in workshop testbenches and as the producer side of pipeline demos.

Parameters:
- DATA_WIDTH, 8, width of vrBus.data.
- DELAY_BITS, 3, width of the delay input and the internal gap counter.
- LEN_BITS, 8, width of num_beats and beats_sent.
- SEED, 'h1, initial data value; must be nonzero when VR_SOURCE_LFSR_EN is defined.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a burst; ignored while busy=1.
- num_beats  input  LEN_BITS  beats in the burst; sampled with start.
- delay  input  DELAY_BITS  idle cycles before each beat; sampled with start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the burst completes.
- beats_sent  output  LEN_BITS  handshakes completed in the current/last burst.
- vrBus  interface  valid_ready.Master  drives valid and data; samples ready.

Behaviour:
- Interface: one clock (clk). reset is asynchronous and active-high.
- Reset (async, immediate, also mid-burst):
  - valid=0, data=0, busy=0, done=0, beats_sent=0.
  - Gap counter=0; state=IDLE.
  - Any in-flight beat is dropped; nothing is replayed after reset.
- All outputs are registered; there are no combinational paths from ready to valid.
- Handshake: a beat transfers on a rising edge where valid && ready.
- Once valid=1 it stays 1 and data stays stable until that handshake. ready may toggle freely.
- States and transitions:
  - IDLE: start=1 latches num_beats and delay, sets data=SEED, beats_sent=0.
    - num_beats=0: go to FINISH.
    - delay=0: go to SEND with valid=1.
    - otherwise: go to GAP with counter=0.
  - GAP: counter increments each cycle. When counter+1==delay, go to SEND and set valid=1 (valid rises delay+1 edges after the start edge).
  - SEND: on handshake, beats_sent+1 and data advances.
    - Last beat (beats_sent+1==num_beats): valid=0, go to FINISH.
    - Else if delay=0: stay in SEND with valid=1 (back-to-back, one beat per cycle).
    - Else: valid=0, counter=0, go to GAP (valid low for exactly delay cycles).
  - FINISH: done=1 for one cycle, busy=0, then IDLE.
- start during busy is ignored. start in the FINISH cycle is ignored. The earliest restart is in IDLE.
- Data advance (default build): data+1 modulo 2^DATA_WIDTH; wraps 'hFF->'h00 for width 8.
- beats_sent does not wrap within a burst (num_beats ≤ 2^LEN_BITS-1).
- beats_sent holds its value after done until the next accepted start.
- delay and num_beats changing mid-burst has no effect.

Optional Feature:
- Macro: VR_SOURCE_LFSR_EN.
- Defined:
  - Data advances as a DATA_WIDTH-bit Galois LFSR (taps from the package), starting at SEED.
  - Never reaches 0; the sequence period is 2^DATA_WIDTH-1.
  - SEED=0 is a configuration error, flagged by an elaboration-time assertion.
- Undefined: the incrementing counter described above.
- Handshake timing is identical in both builds.

Decomposition:
- Package vr_pkg holds:
  - typedef enum logic [1:0] {IDLE, GAP, SEND, FINISH} vr_src_state_t.
  - Function lfsr_taps(width) returning maximal-length tap masks for widths 4..32.
- Sub-module vr_data_gen (params DATA_WIDTH, SEED):
  - Inputs load, advance; output value.
  - Contains the counter/LFSR selected by VR_SOURCE_LFSR_EN.
- vr_source holds the FSM, gap counter and beat counter.

Test Plan:
- delay=0, num_beats=4, ready tied 1 -> valid high 4 consecutive cycles; data 0x01,0x02,0x03,0x04 (SEED=1); done pulse the cycle after; beats_sent=4.
- delay=3, num_beats=3, ready tied 1 -> valid rises 4 edges after start; pattern 1 high / 3 low; data 0x01,0x02,0x03; one done pulse.
- delay=0, num_beats=2, ready held 0 for 5 cycles after valid rises -> valid and data=0x01 stable for all 5 cycles; beats_sent stays 0; completes once ready=1.
- num_beats=0 -> done one cycle after the start edge, valid never asserted; a start pulse while busy in another burst is ignored (beats_sent unchanged).
- Async reset asserted mid-beat with valid=1 -> valid=0 and busy=0 without waiting for a clock edge; a new start gives data 0x01 again.
- SEED=0xFE, delay=0, num_beats=3, ready=1 (default build) -> data 0xFE,0xFF,0x00 (wrap); LFSR build, SEED=1 -> first 3 values match the reference model and none is 0.

Source files
------------

// File: rtl/vr_pkg.sv
// Shared types and helpers for the valid/ready traffic source.
package vr_pkg;

  typedef enum logic [1:0] {IDLE, GAP, SEND, FINISH} vr_src_state_t;

  // Maximal-length Galois tap masks, right-shifting form, for widths 4..32.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      4:  return 32'h0000_0009;
      5:  return 32'h0000_0012;
      6:  return 32'h0000_0021;
      7:  return 32'h0000_0041;
      8:  return 32'h0000_00B8;
      9:  return 32'h0000_0110;
      10: return 32'h0000_0240;
      11: return 32'h0000_0500;
      12: return 32'h0000_0829;
      13: return 32'h0000_100D;
      14: return 32'h0000_2015;
      15: return 32'h0000_6000;
      16: return 32'h0000_D008;
      17: return 32'h0001_2000;
      18: return 32'h0002_0400;
      19: return 32'h0004_0023;
      20: return 32'h0009_0000;
      21: return 32'h0014_0000;
      22: return 32'h0030_0000;
      23: return 32'h0042_0000;
      24: return 32'h00E1_0000;
      25: return 32'h0120_0000;
      26: return 32'h0200_0023;
      27: return 32'h0400_0013;
      28: return 32'h0900_0000;
      29: return 32'h1400_0000;
      30: return 32'h2000_0029;
      31: return 32'h4800_0000;
      32: return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/vr_source_if.sv
// valid/ready handshake bundle. Master drives valid/data, Slave drives ready.
interface valid_ready #(
  parameter int DATA_WIDTH = 8
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport Master (output valid, output data, input ready);
  modport Slave  (input valid, input data, output ready);
endinterface

// File: rtl/vr_data_gen.sv
// Deterministic beat-data generator: incrementing counter by default,
// Galois LFSR when VR_SOURCE_LFSR_EN is defined.
module vr_data_gen #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] SEED       = 'h1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] value
);

  logic [DATA_WIDTH-1:0] next_value;

`ifdef VR_SOURCE_LFSR_EN
  localparam logic [DATA_WIDTH-1:0] TAPS = DATA_WIDTH'(vr_pkg::lfsr_taps(DATA_WIDTH));

  // An all-zero seed locks the LFSR at zero forever.
  if (SEED == '0) begin : g_seed_check
    $error("vr_data_gen: SEED must be nonzero when VR_SOURCE_LFSR_EN is defined");
  end

  // Right-shifting Galois step; the shifted-out bit folds back through the taps.
  always_comb begin
    next_value = value >> 1;
    if (value[0]) next_value = (value >> 1) ^ TAPS;
  end
`else
  // Plain wrap-around increment.
  always_comb begin
    next_value = value + DATA_WIDTH'(1);
  end
`endif

  // Value register: load restarts the pattern, advance steps it after a beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        value <= '0;
    else if (load)    value <= SEED;
    else if (advance) value <= next_value;
  end

endmodule

// File: rtl/vr_source.sv
// Burst traffic generator driving the Master side of a valid_ready bus.
// Optional build macro: VR_SOURCE_LFSR_EN selects LFSR data instead of a counter.
module vr_source
  import vr_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DELAY_BITS = 3,
  parameter int                    LEN_BITS   = 8,
  parameter logic [DATA_WIDTH-1:0] SEED       = 'h1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_BITS-1:0]   num_beats,
  input  logic [DELAY_BITS-1:0] delay,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_BITS-1:0]   beats_sent,
  valid_ready.Master            vrBus
);

  vr_src_state_t         state, state_nxt;
  logic [DELAY_BITS-1:0] cnt, cnt_nxt;
  logic [DELAY_BITS-1:0] dly_q, dly_nxt;
  logic [LEN_BITS-1:0]   nb_q, nb_nxt;
  logic [LEN_BITS-1:0]   beats_nxt;
  logic                  valid_q, valid_nxt;
  logic                  done_nxt, busy_nxt;
  logic                  load, advance, hs;
  logic [DATA_WIDTH-1:0] data_val;

  vr_data_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .SEED       (SEED)
  ) u_data_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .advance (advance),
    .value   (data_val)
  );

  assign vrBus.valid = valid_q;
  assign vrBus.data  = data_val;
  assign hs          = valid_q && vrBus.ready;

  // Next-state and registered-output logic for the burst sequencer.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dly_nxt   = dly_q;
    nb_nxt    = nb_q;
    beats_nxt = beats_sent;
    valid_nxt = valid_q;
    done_nxt  = 1'b0;
    busy_nxt  = busy;
    load      = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          nb_nxt    = num_beats;
          dly_nxt   = delay;
          beats_nxt = '0;
          cnt_nxt   = '0;
          load      = 1'b1;
          if (num_beats == '0) begin
            state_nxt = FINISH;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
          end else begin
            busy_nxt = 1'b1;
            if (delay == '0) begin
              state_nxt = SEND;
              valid_nxt = 1'b1;
            end else begin
              state_nxt = GAP;
            end
          end
        end
      end
      GAP: begin
        if (DELAY_BITS'(cnt + 1'b1) == dly_q) begin
          state_nxt = SEND;
          valid_nxt = 1'b1;
        end else begin
          cnt_nxt = DELAY_BITS'(cnt + 1'b1);
        end
      end
      SEND: begin
        if (hs) begin
          beats_nxt = LEN_BITS'(beats_sent + 1'b1);
          advance   = 1'b1;
          if (LEN_BITS'(beats_sent + 1'b1) == nb_q) begin
            state_nxt = FINISH;
            valid_nxt = 1'b0;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
          end else if (dly_q != '0) begin
            state_nxt = GAP;
            valid_nxt = 1'b0;
            cnt_nxt   = '0;
          end
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and counter registers; reset drops any beat in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      dly_q      <= '0;
      nb_q       <= '0;
      beats_sent <= '0;
      valid_q    <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      dly_q      <= dly_nxt;
      nb_q       <= nb_nxt;
      beats_sent <= beats_nxt;
      valid_q    <= valid_nxt;
      done       <= done_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_vr_source.sv
// Directed bench for vr_source: a SEED=1 instance and a SEED=0xFE instance
// run side by side on shared controls.
module tb_vr_source;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] num_beats;
  logic [2:0] delay;
  logic       rdy;
  logic       busy, done, busy2, done2;
  logic [7:0] beats_sent, beats2;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp1 [4];
  logic [7:0] expfe [3];

  valid_ready #(.DATA_WIDTH(8)) bus ();
  valid_ready #(.DATA_WIDTH(8)) bus2 ();
  assign bus.ready  = rdy;
  assign bus2.ready = rdy;

  vr_source #(.DATA_WIDTH(8), .DELAY_BITS(3), .LEN_BITS(8), .SEED(8'h01)) dut (
    .clk(clk), .reset(reset), .start(start), .num_beats(num_beats), .delay(delay),
    .busy(busy), .done(done), .beats_sent(beats_sent), .vrBus(bus)
  );

  vr_source #(.DATA_WIDTH(8), .DELAY_BITS(3), .LEN_BITS(8), .SEED(8'hFE)) dut_fe (
    .clk(clk), .reset(reset), .start(start), .num_beats(num_beats), .delay(delay),
    .busy(busy2), .done(done2), .beats_sent(beats2), .vrBus(bus2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] nb, input logic [2:0] dl);
    num_beats = nb;
    delay     = dl;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i < 60 && (busy || done); i++) tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; num_beats = '0; delay = '0; rdy = 1'b0;
    #12;
    vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", bus.valid); end
    vectors++; if (bus.data !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h exp 00", bus.data); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b exp 0", done); end
    vectors++; if (beats_sent !== 8'd0) begin miscompares++; $display("FAIL reset_beats got %0d exp 0", beats_sent); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    rdy = 1'b1;
    pulse_start(8'd4, 3'd0);
    for (int i = 0; i < 4; i++) begin
      vectors++; if (bus.valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid[%0d] got %b exp 1", i, bus.valid); end
      vectors++; if (bus.data !== exp1[i]) begin miscompares++; $display("FAIL b2b_data[%0d] got %h exp %h", i, bus.data, exp1[i]); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy[%0d] got %b exp 1", i, busy); end
      tick();
    end
    vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL b2b_valid_end got %b exp 0", bus.valid); end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL b2b_done got %b exp 1", done); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_busy_end got %b exp 0", busy); end
    vectors++; if (beats_sent !== 8'd4) begin miscompares++; $display("FAIL b2b_beats got %0d exp 4", beats_sent); end
    tick();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL b2b_done_pulse got %b exp 0", done); end
    vectors++; if (beats_sent !== 8'd4) begin miscompares++; $display("FAIL b2b_beats_hold got %0d exp 4", beats_sent); end
    settle();
  endtask

  task automatic test_gap();
    int dones = 0;
    rdy = 1'b1;
    pulse_start(8'd3, 3'd3);
    // Start edge is edge 1; valid must be low after edges 1..3 and high after edge 4.
    for (int k = 0; k < 3; k++) begin
      vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL gap_lead[%0d] got %b exp 0", k, bus.valid); end
      if (k < 2) tick();
    end
    tick();
    for (int b = 0; b < 3; b++) begin
      vectors++; if (bus.valid !== 1'b1) begin miscompares++; $display("FAIL gap_valid[%0d] got %b exp 1", b, bus.valid); end
      vectors++; if (bus.data !== exp1[b]) begin miscompares++; $display("FAIL gap_data[%0d] got %h exp %h", b, bus.data, exp1[b]); end
      tick();
      if (done) dones++;
      if (b < 2) begin
        for (int k = 0; k < 3; k++) begin
          vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL gap_low[%0d.%0d] got %b exp 0", b, k, bus.valid); end
          tick();
          if (done) dones++;
        end
      end
    end
    tick();
    if (done) dones++;
    vectors++; if (dones !== 1) begin miscompares++; $display("FAIL gap_done_count got %0d exp 1", dones); end
    vectors++; if (beats_sent !== 8'd3) begin miscompares++; $display("FAIL gap_beats got %0d exp 3", beats_sent); end
    settle();
  endtask

  task automatic test_stall();
    rdy = 1'b0;
    pulse_start(8'd2, 3'd0);
    for (int k = 0; k < 5; k++) begin
      vectors++; if (bus.valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid[%0d] got %b exp 1", k, bus.valid); end
      vectors++; if (bus.data !== exp1[0]) begin miscompares++; $display("FAIL stall_data[%0d] got %h exp %h", k, bus.data, exp1[0]); end
      vectors++; if (beats_sent !== 8'd0) begin miscompares++; $display("FAIL stall_beats[%0d] got %0d exp 0", k, beats_sent); end
      tick();
    end
    rdy = 1'b1;
    vectors++; if (bus.data !== exp1[0]) begin miscompares++; $display("FAIL stall_data_rel got %h exp %h", bus.data, exp1[0]); end
    tick();
    vectors++; if (bus.data !== exp1[1]) begin miscompares++; $display("FAIL stall_data2 got %h exp %h", bus.data, exp1[1]); end
    vectors++; if (beats_sent !== 8'd1) begin miscompares++; $display("FAIL stall_beats1 got %0d exp 1", beats_sent); end
    tick();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL stall_done got %b exp 1", done); end
    vectors++; if (beats_sent !== 8'd2) begin miscompares++; $display("FAIL stall_beats2 got %0d exp 2", beats_sent); end
    settle();
  endtask

  task automatic test_zero_beats();
    logic seen = 1'b0;
    rdy = 1'b1;
    pulse_start(8'd0, 3'd0);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL zero_done got %b exp 1", done); end
    vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL zero_valid got %b exp 0", bus.valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL zero_busy got %b exp 0", busy); end
    tick();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL zero_done_pulse got %b exp 0", done); end
    vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL zero_valid2 got %b exp 0", bus.valid); end
    settle();
    // A second start while busy must not restart or resize the burst.
    pulse_start(8'd2, 3'd2);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ign_busy got %b exp 1", busy); end
    tick();
    pulse_start(8'd5, 3'd0);
    for (int i = 0; i < 30 && !seen; i++) begin
      if (done) seen = 1'b1;
      else tick();
    end
    vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL ign_done_timeout got %b exp 1", seen); end
    vectors++; if (beats_sent !== 8'd2) begin miscompares++; $display("FAIL ign_beats got %0d exp 2", beats_sent); end
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ign_idle got %b exp 0", busy); end
    settle();
  endtask

  task automatic test_async_reset();
    rdy = 1'b0;
    pulse_start(8'd4, 3'd0);
    vectors++; if (bus.valid !== 1'b1) begin miscompares++; $display("FAIL ar_pre_valid got %b exp 1", bus.valid); end
    #2 reset = 1'b1;
    #1;
    vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL ar_valid got %b exp 0", bus.valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ar_busy got %b exp 0", busy); end
    vectors++; if (bus.data !== 8'h00) begin miscompares++; $display("FAIL ar_data got %h exp 00", bus.data); end
    #1 reset = 1'b0;
    tick();
    vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL ar_no_replay got %b exp 0", bus.valid); end
    rdy = 1'b1;
    pulse_start(8'd1, 3'd0);
    vectors++; if (bus.valid !== 1'b1) begin miscompares++; $display("FAIL ar_restart_valid got %b exp 1", bus.valid); end
    vectors++; if (bus.data !== exp1[0]) begin miscompares++; $display("FAIL ar_restart_data got %h exp %h", bus.data, exp1[0]); end
    settle();
  endtask

  task automatic test_wrap();
    rdy = 1'b1;
    pulse_start(8'd3, 3'd0);
    for (int i = 0; i < 3; i++) begin
      vectors++; if (bus2.data !== expfe[i]) begin miscompares++; $display("FAIL wrap_data[%0d] got %h exp %h", i, bus2.data, expfe[i]); end
      vectors++; if (bus.data !== exp1[i]) begin miscompares++; $display("FAIL seq_data[%0d] got %h exp %h", i, bus.data, exp1[i]); end
`ifdef VR_SOURCE_LFSR_EN
      vectors++; if (bus.data === 8'h00) begin miscompares++; $display("FAIL lfsr_nonzero[%0d] got %h exp nonzero", i, bus.data); end
`endif
      tick();
    end
    vectors++; if (done2 !== 1'b1) begin miscompares++; $display("FAIL wrap_done got %b exp 1", done2); end
    vectors++; if (beats2 !== 8'd3) begin miscompares++; $display("FAIL wrap_beats got %0d exp 3", beats2); end
    vectors++; if (busy2 !== 1'b0) begin miscompares++; $display("FAIL wrap_busy got %b exp 0", busy2); end
    settle();
  endtask

  initial begin
`ifdef VR_SOURCE_LFSR_EN
    // Galois right-shift, taps 0xB8: 01->B8->5C->2E ; FE->7F->87
    exp1  = '{8'h01, 8'hB8, 8'h5C, 8'h2E};
    expfe = '{8'hFE, 8'h7F, 8'h87};
`else
    exp1  = '{8'h01, 8'h02, 8'h03, 8'h04};
    expfe = '{8'hFE, 8'hFF, 8'h00};
`endif
    test_reset();
    test_back_to_back();
    test_gap();
    test_stall();
    test_zero_beats();
    test_async_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
